apb_tgt_regfile: RTL

APB_TGT_REGFILE -- requirements
Module: apb_tgt_regfile

---
 rtl/apb_tgt_regfile_pkg.sv | 26 ++
 rtl/apb_tgt_wait_cnt.sv | 26 ++
 rtl/apb_tgt_regfile.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/apb_tgt_regfile_pkg.sv
// Shared definitions for the APB target register file: offsets, FSM states, ID default.
package apb_tgt_regfile_pkg;

  localparam logic [4:0] OffCtrl    = 5'h00;
  localparam logic [4:0] OffStatus  = 5'h04;
  localparam logic [4:0] OffScratch0 = 5'h08;
  localparam logic [4:0] OffScratch1 = 5'h0C;
  localparam logic [4:0] OffIrqEn   = 5'h10;
  localparam logic [4:0] OffIrqPend = 5'h14;
  localparam logic [4:0] OffId      = 5'h18;
  localparam logic [4:0] OffRsvd    = 5'h1C;

  localparam logic [31:0] IdValueDefault = 32'h5043_0001;

  typedef enum logic {
    StIdle,
    StAccess
  } apb_state_e;

  // Misaligned, reserved, or write to a read-only register.
  function automatic logic addr_err(input logic [4:0] off, input logic wr);
    return (off[1:0] != 2'b00) || (off == OffRsvd) ||
           (wr && ((off == OffStatus) || (off == OffId)));
  endfunction

endpackage

// File: rtl/apb_tgt_wait_cnt.sv
// Wait-state counter: loads at setup, counts down to zero during the access phase.
module apb_tgt_wait_cnt (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/apb_tgt_regfile.sv
// APB target with a small control/status register file, wait states, IRQ and protocol checking.
module apb_tgt_regfile
  import apb_tgt_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = IdValueDefault
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  input  logic [DATA_WIDTH-1:0] status_i,
  output logic                  irq_o,
  output logic                  proto_err_o
);

  localparam logic [DATA_WIDTH-1:0] IdVal = DATA_WIDTH'(ID_VALUE);

  apb_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_status_snap;
  logic [DATA_WIDTH-1:0] r_status_q;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_scratch0;
  logic [DATA_WIDTH-1:0] r_scratch1;
  logic [DATA_WIDTH-1:0] r_irq_en;
  logic [DATA_WIDTH-1:0] r_irq_pend;
  logic                  r_irq;
  logic                  r_proto_err;

  logic                  w_zero;
  logic                  w_setup;
  logic                  w_match;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_err;
  logic                  w_commit;
  logic [4:0]            w_off;
  logic [DATA_WIDTH-1:0] w_rmux;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_clr;

  assign w_off    = r_addr[4:0];
  assign w_setup  = (r_state == StIdle) && psel && !penable;
  // The master must hold select, enable, address and direction for the whole access phase.
  assign w_match  = psel && penable && (paddr == r_addr) && (pwrite == r_write);
  assign w_done   = (r_state == StAccess) && w_zero && w_match;
  assign w_abort  = (r_state == StAccess) && !w_match;
  assign w_err    = addr_err(w_off, r_write);
  assign w_commit = w_done && r_write && !w_err;
  assign w_rise   = status_i & ~r_status_q;
  assign w_clr    = (w_commit && (w_off == OffIrqPend)) ? r_wdata : '0;

  apb_tgt_wait_cnt u_wait_cnt (
    .i_clk      (pclk),
    .i_rst      (prst),
    .i_load     (w_setup),
    .i_load_val (4'(WAIT_CYCLES)),
    .i_dec      (r_state == StAccess),
    .o_zero     (w_zero)
  );

  // Transfer FSM: latch the request at setup, finish or abort in access.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state     <= StIdle;
      r_proto_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (psel && penable) begin
            r_proto_err <= 1'b1;
          end else if (psel) begin
            r_state       <= StAccess;
            r_addr        <= paddr;
            r_write       <= pwrite;
            r_wdata       <= pwdata;
            r_status_snap <= status_i;
          end
        end
        StAccess: begin
          if (w_abort) begin
            r_proto_err <= 1'b1;
            r_state     <= StIdle;
          end else if (w_zero) begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  // Register file, edge-detected interrupt pending bits and registered interrupt output.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_ctrl     <= '0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_irq_en   <= '0;
      r_irq_pend <= '0;
      r_status_q <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_status_q <= status_i;
      // A rising status bit beats a simultaneous write-one-to-clear.
      r_irq_pend <= (r_irq_pend & ~w_clr) | w_rise;
      r_irq      <= |(r_irq_pend & r_irq_en);
      if (w_commit) begin
        case (w_off)
          OffCtrl:     r_ctrl     <= r_wdata;
          OffScratch0: r_scratch0 <= r_wdata;
          OffScratch1: r_scratch1 <= r_wdata;
          OffIrqEn:    r_irq_en   <= r_wdata;
          default: ;
        endcase
      end
    end
  end

  // Read data mux over the latched offset.
  always_comb begin
    w_rmux = '0;
    case (w_off)
      OffCtrl:     w_rmux = r_ctrl;
      OffStatus:   w_rmux = r_status_snap;
      OffScratch0: w_rmux = r_scratch0;
      OffScratch1: w_rmux = r_scratch1;
      OffIrqEn:    w_rmux = r_irq_en;
      OffIrqPend:  w_rmux = r_irq_pend;
      OffId:       w_rmux = IdVal;
      default:     w_rmux = '0;
    endcase
  end

  assign pready      = !prst && (r_state == StAccess) && w_zero;
  assign pslverr     = pready && w_err;
  assign prdata      = (pready && !r_write && !w_err) ? w_rmux : '0;
  assign ctrl_o      = r_ctrl;
  assign irq_o       = r_irq && !prst;
  assign proto_err_o = r_proto_err && !prst;

endmodule
